// File: rtl/spi_regslave.sv
// SPI mode-0 register slave: oversampled SCLK/SS/MOSI, frame = mode bit + address + data, MSB first.
// Presents a single-clock write strobe / read request bus with read-data timeout and abort reporting.
module spi_regslave #(
  parameter int                ADDR_W = 4,
  parameter int                DATA_W = 8,
  parameter logic [DATA_W-1:0] RDFILL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spiclk,
  input  logic              spien,
  input  logic              spidin,
  output logic              spidout,
  output logic              spioe,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wrtdata,
  output logic              wrstb,
  output logic              rdreq,
  input  logic [DATA_W-1:0] rddata,
  input  logic              rdvalid,
  output logic              abort,
  output logic              rderr
);
  localparam int            CW      = $clog2(ADDR_W + DATA_W + 2);
  localparam logic [CW-1:0] CNT_A   = CW'(ADDR_W);
  localparam logic [CW-1:0] CNT_D   = CW'(ADDR_W + DATA_W);
  localparam logic [CW-1:0] CNT_MAX = CW'(ADDR_W + DATA_W + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_MODE, S_ADDR, S_RDWAIT, S_RDATA, S_WDATA, S_DONE
  } state_t;

  state_t r_state, w_next;

  logic [2:0]        r_sck_s, r_en_s;
  logic [1:0]        r_din_s;
  logic [CW-1:0]     r_cnt;
  logic              r_mode;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wsh, r_wrtdata, r_shift;
  logic              r_wrstb, r_rdreq, r_abort, r_rderr, r_oe, r_dout;

  logic w_en, w_en_rise, w_en_fall, w_rise, w_fall, w_din, w_busy, w_abort;
  logic w_last_a, w_last_d;
  logic [ADDR_W-1:0] w_addr_next;
  logic [DATA_W-1:0] w_wsh_next, w_sh_next;

  // Synchronisers carry no reset so a held SS is not seen as a fresh rise after reset.
  always_ff @(posedge clk) begin
    r_sck_s <= {r_sck_s[1:0], spiclk};
    r_en_s  <= {r_en_s[1:0], spien};
    r_din_s <= {r_din_s[0], spidin};
  end

  assign w_en        = r_en_s[1];
  assign w_en_rise   = r_en_s[1] & ~r_en_s[2];
  assign w_en_fall   = ~r_en_s[1] & r_en_s[2];
  assign w_rise      = w_en & r_sck_s[1] & ~r_sck_s[2];
  assign w_fall      = w_en & ~r_sck_s[1] & r_sck_s[2];
  assign w_din       = r_din_s[1];
  assign w_busy      = (r_state != S_IDLE) && (r_state != S_DONE);
  assign w_abort     = w_busy & (w_en_fall | w_en_rise);
  assign w_last_a    = w_rise && (r_cnt == CNT_A);
  assign w_last_d    = w_rise && (r_cnt == CNT_D);
  assign w_addr_next = ADDR_W'({r_addr, w_din});
  assign w_wsh_next  = DATA_W'({r_wsh, w_din});
  assign w_sh_next   = r_shift << 1;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (w_en_rise)      w_next = S_MODE;
    else if (w_en_fall) w_next = S_IDLE;
    else begin
      case (r_state)
        S_MODE:           if (w_rise)   w_next = S_ADDR;
        S_ADDR:           if (w_last_a) w_next = r_mode ? S_RDWAIT : S_WDATA;
        S_RDWAIT:         if (w_fall)   w_next = S_RDATA;
        S_RDATA, S_WDATA: if (w_last_d) w_next = S_DONE;
        default:          ;
      endcase
    end
  end

  // Bit counter tracks SCLK rises across the whole frame and parks at CNT_MAX.
  always_ff @(posedge clk) begin
    if (reset || w_en_rise || w_en_fall) r_cnt <= '0;
    else if (w_rise && w_busy && r_cnt != CNT_MAX) r_cnt <= r_cnt + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mode    <= 1'b0;
      r_addr    <= '0;
      r_wsh     <= '0;
      r_wrtdata <= '0;
      r_shift   <= '0;
      r_wrstb   <= 1'b0;
      r_rdreq   <= 1'b0;
      r_abort   <= 1'b0;
      r_rderr   <= 1'b0;
      r_oe      <= 1'b0;
      r_dout    <= 1'b0;
    end else begin
      r_wrstb <= 1'b0;
      r_abort <= w_abort;
      if (w_en_rise) r_rderr <= 1'b0;
      if (w_en_rise || w_en_fall) begin
        r_rdreq <= 1'b0;
        r_oe    <= 1'b0;
        r_dout  <= 1'b0;
      end else begin
        case (r_state)
          S_MODE: if (w_rise) r_mode <= w_din;
          S_ADDR: if (w_rise) begin
            r_addr <= w_addr_next;
            if (w_last_a && r_mode) r_rdreq <= 1'b1;
          end
          // A fall with the request still open means the bus missed its slot: send the fill pattern.
          S_RDWAIT: if (w_fall) begin
            r_rdreq <= 1'b0;
            r_oe    <= 1'b1;
            if (r_rdreq) begin
              r_shift <= RDFILL;
              r_dout  <= RDFILL[DATA_W-1];
              r_rderr <= 1'b1;
            end else begin
              r_dout  <= r_shift[DATA_W-1];
            end
          end else if (r_rdreq && rdvalid) begin
            r_shift <= rddata;
            r_rdreq <= 1'b0;
          end
          S_RDATA: if (w_last_d) r_dout <= 1'b0;
                   else if (w_fall) begin
                     r_shift <= w_sh_next;
                     r_dout  <= w_sh_next[DATA_W-1];
                   end
          S_WDATA: if (w_rise) begin
            r_wsh <= w_wsh_next;
            if (w_last_d) begin
              r_wrtdata <= w_wsh_next;
              r_wrstb   <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign spidout = r_dout;
  assign spioe   = r_oe;
  assign addr    = r_addr;
  assign wrtdata = r_wrtdata;
  assign wrstb   = r_wrstb;
  assign rdreq   = r_rdreq;
  assign abort   = r_abort;
  assign rderr   = r_rderr;
endmodule
